// File: rtl/vector_issue_queue.sv
// vector_issue_queue
//   Command buffer and dispatcher in front of the vector execution unit.
//   Host commands are held in a depth_p-entry in-order FIFO. They are issued
//   one at a time over a valid/ready handshake. The queue then waits for the
//   unit's done pulse before issuing the next one. Read results are returned
//   to the host on a separate response port. Illegal opcodes are dropped and
//   set a sticky error flag.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   cmd_*                   host command port (valid/ready), op/addr/scalar/payload
//   unit_v_o / unit_ready_i issue handshake to the execution unit
//   unit_*_o                FIFO head fields presented with unit_v_o
//   unit_done_i / unit_yumi_o completion handshake, unit_r_data_i valid with done
//   resp_v_o / resp_data_o / resp_yumi_i  read response to the host
//   busy_o                  queue non-empty or instruction outstanding
//   illegal_o               sticky illegal-opcode flag
//   count_o                 FIFO occupancy
module vector_issue_queue #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int vdw_p   = 8,
  parameter int depth_p = 4,
  localparam int v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int data_width_lp   = vlen_p * vdw_p,
  localparam int ptr_width_lp    = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic [3:0]                 cmd_op_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrA_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrB_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrC_i,
  input  logic [vdw_p-1:0]           cmd_scalar_i,
  input  logic [data_width_lp-1:0]   cmd_w_data_i,

  output logic                       unit_v_o,
  input  logic                       unit_ready_i,
  output logic [3:0]                 unit_op_o,
  output logic [v_addr_width_lp-1:0] unit_addrA_o,
  output logic [v_addr_width_lp-1:0] unit_addrB_o,
  output logic [v_addr_width_lp-1:0] unit_addrC_o,
  output logic [vdw_p-1:0]           unit_scalar_o,
  output logic [data_width_lp-1:0]   unit_w_data_o,
  input  logic                       unit_done_i,
  input  logic [data_width_lp-1:0]   unit_r_data_i,
  output logic                       unit_yumi_o,

  output logic                       resp_v_o,
  output logic [data_width_lp-1:0]   resp_data_o,
  input  logic                       resp_yumi_i,

  output logic                       busy_o,
  output logic                       illegal_o,
  output logic [ptr_width_lp:0]      count_o
);

  localparam logic [ptr_width_lp:0] full_lp = (ptr_width_lp+1)'(depth_p);
  localparam logic [3:0] op_read_lp = 4'b1000;

  typedef enum logic [1:0] {s_ISSUE, s_WAIT, s_RESP} state_e;

  state_e state_r, state_n;

  logic [3:0]                 op_mem     [depth_p];
  logic [v_addr_width_lp-1:0] addr_a_mem [depth_p];
  logic [v_addr_width_lp-1:0] addr_b_mem [depth_p];
  logic [v_addr_width_lp-1:0] addr_c_mem [depth_p];
  logic [vdw_p-1:0]           scalar_mem [depth_p];
  logic [data_width_lp-1:0]   w_data_mem [depth_p];

  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [ptr_width_lp:0]   count_r;
  logic [3:0]              cur_op_r;
  logic [data_width_lp-1:0] resp_data_r;
  logic                    illegal_r;

  logic cmd_legal, cmd_hs, enq, deq;

  always_comb begin
    case (cmd_op_i)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1001: cmd_legal = 1'b1;
      default:          cmd_legal = 1'b0;
    endcase
  end

  // Ready depends only on the registered count, so a full queue stalls the
  // host even in a cycle where the head is being popped.
  assign cmd_ready_o = (count_r != full_lp);
  assign cmd_hs      = cmd_v_i & cmd_ready_o;
  assign enq         = cmd_hs & cmd_legal;
  assign deq         = unit_v_o & unit_ready_i;

  // Storage is cleared on reset so every output reads zero until the first
  // command arrives.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < depth_p; i++) begin
        op_mem[i]     <= '0;
        addr_a_mem[i] <= '0;
        addr_b_mem[i] <= '0;
        addr_c_mem[i] <= '0;
        scalar_mem[i] <= '0;
        w_data_mem[i] <= '0;
      end
    end else if (enq) begin
      op_mem[wptr_r]     <= cmd_op_i;
      addr_a_mem[wptr_r] <= cmd_addrA_i;
      addr_b_mem[wptr_r] <= cmd_addrB_i;
      addr_c_mem[wptr_r] <= cmd_addrC_i;
      scalar_mem[wptr_r] <= cmd_scalar_i;
      w_data_mem[wptr_r] <= cmd_w_data_i;
    end
  end

  // Pointers wrap naturally because depth_p is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      count_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      if (enq) wptr_r <= wptr_r + 1'b1;
      if (deq) rptr_r <= rptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (cmd_hs && !cmd_legal) illegal_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= s_ISSUE;
      cur_op_r    <= '0;
      resp_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (deq) cur_op_r <= op_mem[rptr_r];
      if (state_r == s_WAIT && unit_done_i && cur_op_r == op_read_lp)
        resp_data_r <= unit_r_data_i;
    end
  end

  always_comb begin
    state_n     = state_r;
    unit_v_o    = 1'b0;
    unit_yumi_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_r)
      s_ISSUE: begin
        unit_v_o = (count_r != '0);
        if (unit_v_o && unit_ready_i) state_n = s_WAIT;
      end
      s_WAIT: begin
        unit_yumi_o = unit_done_i;
        if (unit_done_i) state_n = (cur_op_r == op_read_lp) ? s_RESP : s_ISSUE;
      end
      s_RESP: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_n = s_ISSUE;
      end
      default: state_n = s_ISSUE;
    endcase
  end

  assign unit_op_o     = op_mem[rptr_r];
  assign unit_addrA_o  = addr_a_mem[rptr_r];
  assign unit_addrB_o  = addr_b_mem[rptr_r];
  assign unit_addrC_o  = addr_c_mem[rptr_r];
  assign unit_scalar_o = scalar_mem[rptr_r];
  assign unit_w_data_o = w_data_mem[rptr_r];

  assign resp_data_o = resp_data_r;
  assign busy_o      = (count_r != '0) | (state_r != s_ISSUE);
  assign illegal_o   = illegal_r;
  assign count_o     = count_r;

endmodule
